aclock_load_arbiter: RTL and testbench
======================================

# aclock_load_arbiter

Arbitrates time-load and alarm-load requests from two independent requesters onto the single configuration port of the `aclock` alarm-clock core. It validates the BCD payload, drives the digit inputs and the `LD_time`/`LD_alarm` strobe for a programmable width, and, for time loads, reads back the clock outputs to confirm the load. It sits between the host-side configuration agents and `aclock`, and owns `H_in1/H_in0/M_in1/M_in0/LD_time/LD_alarm`.

## Interface
- `LD_CYCLES`, default 2: load-strobe width in clocks; must be ≥1.
- `SETTLE_CYCLES`, default 2: wait after the strobe before time readback; must be ≥1.

- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0`, `req1` in 1: request; held high until the matching ack is seen.
- `kind0`, `kind1` in 1: 0 = time load, 1 = alarm load.
- `hh0`, `hh1` in 6: `{H1[1:0], H0[3:0]}` BCD hours.
- `mm0`, `mm1` in 8: `{M1[3:0], M0[3:0]}` BCD minutes.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `err` out 1: valid only with an ack; 1 = rejected or readback mismatch.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out 1: requester currently served; holds the last grant when idle.
- `H_in1` out 2, `H_in0` out 4, `M_in1` out 4, `M_in0` out 4: digits to `aclock`.
- `LD_time`, `LD_alarm` out 1: load strobes to `aclock`.
- `H_out1` in 2, `H_out0` in 4, `M_out1` in 4, `M_out0` in 4: readback from `aclock`.

## Operation
- States: IDLE, LOAD, SETTLE, VERIFY, RESP.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If one request is high, grant it.
  - If both are high, grant the requester other than `last_grant` (round-robin). `last_grant` resets to 1, so `req0` wins the first tie.
  - On a grant: latch kind, hh and mm; update `grant_id` and `last_grant`.
- **Validation** (combinational on the latched payload, evaluated in the grant cycle):
  - H1 ≤ 2 and H0 ≤ 9; if H1 = 2 then H0 ≤ 3.
  - M1 ≤ 5 and M0 ≤ 9.
  - Invalid payload: go to RESP with err = 1. No strobe is issued and the digit outputs stay 0.
  - Valid payload: go to LOAD.
- **LOAD** (`LD_CYCLES` cycles)
  - Digit outputs carry the latched payload.
  - `LD_time` is high if kind = 0; `LD_alarm` is high if kind = 1. Never both.
  - At the end: time loads go to SETTLE; alarm loads go to RESP with err = 0.
- **SETTLE** (`SETTLE_CYCLES` cycles): both strobes low; digits held.
- **VERIFY** (1 cycle)
  - Register the compare of `{H_out1, H_out0, M_out1, M_out0}` against the latched payload. Mismatch sets err = 1.
  - Then go to RESP.
- **RESP** (1 cycle): assert `ack` of `grant_id` together with `err`, then go to IDLE.
- Digit outputs are 0 outside LOAD, SETTLE and VERIFY.
- Request inputs are ignored outside IDLE. The payload is captured only at grant.
- Reset values: state IDLE, every output 0, `last_grant` 1.
- Reset during any state returns to IDLE within one cycle. The strobe drops and no ack is issued. Requests still held are re-arbitrated after reset releases.

## Timing
- The grant happens at the edge where IDLE samples `req`. Call that edge E0; the cycle after it is c1.
- Valid time load:
  - LOAD: c1..c`LD_CYCLES`.
  - SETTLE: the next `SETTLE_CYCLES` cycles.
  - VERIFY: 1 cycle.
  - RESP with ack: defaults give LOAD c1–c2, SETTLE c3–c4, VERIFY c5, ack in c6.
- Valid alarm load: ack in cycle `LD_CYCLES`+1 (c3 with defaults).
- Invalid payload: ack in c1.
- Ack is a registered, one-cycle pulse.
- The requester drops `req` on the edge where it samples ack = 1. IDLE samples `req` one edge later, so a correctly behaving requester is never double-granted.
- Back-to-back service: the second requester's grant occurs at the edge ending RESP+1 (first IDLE cycle). Minimum 1 idle cycle between services.

## Test plan
- Reset then `req0` = 1, time load, hh = 6'h12, mm = 8'h34; model echoes the digits → `LD_time` high c1–c2, `H_in1` = 1, `H_in0` = 2, `M_in1` = 3, `M_in0` = 4; `ack0` = 1 with `err` = 0 in c6.
- `req1` alarm load, hh = 6'h07, mm = 8'h30 → `LD_alarm` high c1–c2, `LD_time` stays 0; `ack1` in c3, `err` = 0.
- Invalid payloads hh = 6'h24, then mm = 8'h60 → no strobe, digits stay 0, ack in c1 with `err` = 1.
- Both requests high from reset → `req0` served first, then `req1`. With both re-asserted continuously, grants alternate 0,1,0,1; `grant_id` tracks each grant.
- Time load with the model returning `M_out0` = 5 when 4 was loaded → ack with `err` = 1.
- Assert `reset` in the second LOAD cycle → strobe low the next cycle, all outputs 0, no ack. The held `req0` is re-granted after release and completes normally.

Source files
------------

// File: rtl/aclock_load_arbiter_if.sv
// Configuration bus between the host-side load requesters, the arbiter and
// the aclock core. Valid/ready contract: a requester raises reqN with a
// stable payload and holds it until it samples ackN = 1; ackN is a one-cycle
// pulse and err qualifies it in that same cycle only.
interface aclock_load_arbiter_if;
    // Requester side
    logic       req0;
    logic       req1;
    logic       kind0;
    logic       kind1;
    logic [5:0] hh0;
    logic [5:0] hh1;
    logic [7:0] mm0;
    logic [7:0] mm1;
    logic       ack0;
    logic       ack1;
    logic       err;
    logic       busy;
    logic       grant_id;

    // aclock side
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0;
    logic [3:0] M_out1;
    logic [3:0] M_out0;

    // Arbiter view
    modport slave (
        input  req0, req1, kind0, kind1, hh0, hh1, mm0, mm1,
        input  H_out1, H_out0, M_out1, M_out0,
        output ack0, ack1, err, busy, grant_id,
        output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm
    );

    // Environment view (requesters plus aclock)
    modport master (
        output req0, req1, kind0, kind1, hh0, hh1, mm0, mm1,
        output H_out1, H_out0, M_out1, M_out0,
        input  ack0, ack1, err, busy, grant_id,
        input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm
    );
endinterface

// File: rtl/aclock_load_arbiter.sv
// Round-robin arbiter that loads time or alarm values into the aclock core.
// A granted payload is BCD-checked, driven with a LD_time/LD_alarm strobe of
// LD_CYCLES clocks, and for time loads read back after SETTLE_CYCLES to
// confirm the core actually took the value.
module aclock_load_arbiter #(
    parameter int LD_CYCLES     = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    aclock_load_arbiter_if.slave   bus,
    output logic [2:0]             dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_VERIFY = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    localparam int CNT_MAX = (LD_CYCLES > SETTLE_CYCLES) ? LD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] LD_LAST     = CNT_W'(LD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    // Hours {H1[1:0],H0[3:0]} must be 00..23, minutes {M1,M0} must be 00..59.
    function automatic logic payload_ok(input logic [5:0] hh, input logic [7:0] mm);
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        h1 = hh[5:4];
        h0 = hh[3:0];
        m1 = mm[7:4];
        m0 = mm[3:0];
        return (h1 <= 2'd2) && (h0 <= 4'd9) && !((h1 == 2'd2) && (h0 > 4'd3)) &&
               (m1 <= 4'd5) && (m0 <= 4'd9);
    endfunction

    // Registered state
    state_e           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             kind_q,       kind_d;
    logic [5:0]       hh_q,         hh_d;
    logic [7:0]       mm_q,         mm_d;
    logic             grant_q,      grant_d;
    logic             last_grant_q, last_grant_d;
    logic             err_q,        err_d;

    // Arbitration candidate (meaningful only while IDLE sees a request)
    logic             any_req;
    logic             sel;
    logic             cand_kind;
    logic [5:0]       cand_hh;
    logic [7:0]       cand_mm;
    logic             cand_ok;

    // Readback and output decode helpers
    logic [13:0]      readback;
    logic             digits_en;

    // Pick the requester: a lone request wins, a tie goes to the one not served last.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            sel = ~last_grant_q;
        end else begin
            sel = bus.req1;
        end
        cand_kind = sel ? bus.kind1 : bus.kind0;
        cand_hh   = sel ? bus.hh1   : bus.hh0;
        cand_mm   = sel ? bus.mm1   : bus.mm0;
        cand_ok   = payload_ok(cand_hh, cand_mm);
    end

    assign readback = {bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0};

    // Next-state logic: grant in IDLE, time the strobe and settle windows, then respond.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        kind_d       = kind_q;
        hh_d         = hh_q;
        mm_d         = mm_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    kind_d       = cand_kind;
                    hh_d         = cand_hh;
                    mm_d         = cand_mm;
                    cnt_d        = '0;
                    if (cand_ok) begin
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        // Rejected payload: answer straight away, never strobe.
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end

            S_LOAD: begin
                if (cnt_q == LD_LAST) begin
                    cnt_d = '0;
                    if (kind_q) begin
                        // Alarm registers have no readback path; done after the strobe.
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_VERIFY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_VERIFY: begin
                err_d   = (readback != {hh_q, mm_q});
                state_d = S_RESP;
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            kind_q       <= 1'b0;
            hh_q         <= '0;
            mm_q         <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kind_q       <= kind_d;
            hh_q         <= hh_d;
            mm_q         <= mm_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    // Outputs decode straight from registers, so ack/strobes are glitch-free
    // and drop in the cycle after reset is sampled.
    assign digits_en = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_VERIFY);

    assign bus.H_in1    = digits_en ? hh_q[5:4] : 2'd0;
    assign bus.H_in0    = digits_en ? hh_q[3:0] : 4'd0;
    assign bus.M_in1    = digits_en ? mm_q[7:4] : 4'd0;
    assign bus.M_in0    = digits_en ? mm_q[3:0] : 4'd0;

    assign bus.LD_time  = (state_q == S_LOAD) && !kind_q;
    assign bus.LD_alarm = (state_q == S_LOAD) &&  kind_q;

    assign bus.ack0     = (state_q == S_RESP) && !grant_q;
    assign bus.ack1     = (state_q == S_RESP) &&  grant_q;
    assign bus.err      = (state_q == S_RESP) &&  err_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.grant_id = grant_q;

    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_aclock_load_arbiter.sv
// Directed bench for aclock_load_arbiter with a small aclock time-register model.
module tb_aclock_load_arbiter;

    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;
    logic       corrupt;
    logic [13:0] model_q = '0;

    int n_checks = 0;
    int n_errors = 0;

    aclock_load_arbiter_if bus_if ();

    aclock_load_arbiter #(
        .LD_CYCLES     (2),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // aclock time register model: captures the digits while LD_time is high
    always @(posedge clk) begin
        if (bus_if.LD_time) begin
            model_q <= {bus_if.H_in1, bus_if.H_in0, bus_if.M_in1, bus_if.M_in0};
        end
    end
    assign {bus_if.H_out1, bus_if.H_out0, bus_if.M_out1, bus_if.M_out0} = model_q ^ {13'd0, corrupt};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_digits(input string tag, input logic [5:0] hh, input logic [7:0] mm);
        chk({tag, "_digits"}, {18'd0, bus_if.H_in1, bus_if.H_in0, bus_if.M_in1, bus_if.M_in0},
            {18'd0, hh, mm});
    endtask

    initial begin
        reset       = 1'b1;
        corrupt     = 1'b0;
        bus_if.req0 = 1'b0;  bus_if.req1 = 1'b0;
        bus_if.kind0 = 1'b0; bus_if.kind1 = 1'b0;
        bus_if.hh0 = '0;     bus_if.hh1 = '0;
        bus_if.mm0 = '0;     bus_if.mm1 = '0;

        // Reset state
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_state", dbg_state, 0);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_grant", bus_if.grant_id, 0);
        chk("rst_ack", {bus_if.ack0, bus_if.ack1, bus_if.err}, 0);
        chk("rst_strobe", {bus_if.LD_time, bus_if.LD_alarm}, 0);
        chk_digits("rst", 6'h00, 8'h00);

        // Time load 12:34 from requester 0, echoed by the model
        bus_if.req0 = 1'b1; bus_if.kind0 = 1'b0; bus_if.hh0 = 6'h12; bus_if.mm0 = 8'h34;
        tick();  // c1
        chk("t1_c1_ldtime", bus_if.LD_time, 1);
        chk("t1_c1_ldalarm", bus_if.LD_alarm, 0);
        chk("t1_c1_busy", bus_if.busy, 1);
        chk("t1_c1_grant", bus_if.grant_id, 0);
        chk_digits("t1_c1", 6'h12, 8'h34);
        tick();  // c2
        chk("t1_c2_ldtime", bus_if.LD_time, 1);
        tick();  // c3
        chk("t1_c3_ldtime", bus_if.LD_time, 0);
        chk_digits("t1_c3", 6'h12, 8'h34);
        tick();  // c4
        tick();  // c5
        chk("t1_c5_ack", {bus_if.ack0, bus_if.ack1}, 0);
        tick();  // c6
        chk("t1_c6_ack0", bus_if.ack0, 1);
        chk("t1_c6_ack1", bus_if.ack1, 0);
        chk("t1_c6_err", bus_if.err, 0);
        bus_if.req0 = 1'b0;
        tick();
        chk("t1_idle_ack", bus_if.ack0, 0);
        chk("t1_idle_busy", bus_if.busy, 0);
        chk_digits("t1_idle", 6'h00, 8'h00);

        // Alarm load 07:30 from requester 1
        bus_if.req1 = 1'b1; bus_if.kind1 = 1'b1; bus_if.hh1 = 6'h07; bus_if.mm1 = 8'h30;
        tick();  // c1
        chk("t2_c1_ldalarm", bus_if.LD_alarm, 1);
        chk("t2_c1_ldtime", bus_if.LD_time, 0);
        chk("t2_c1_grant", bus_if.grant_id, 1);
        chk_digits("t2_c1", 6'h07, 8'h30);
        tick();  // c2
        chk("t2_c2_ldalarm", bus_if.LD_alarm, 1);
        chk("t2_c2_ldtime", bus_if.LD_time, 0);
        tick();  // c3
        chk("t2_c3_ack1", bus_if.ack1, 1);
        chk("t2_c3_ack0", bus_if.ack0, 0);
        chk("t2_c3_err", bus_if.err, 0);
        chk("t2_c3_ldalarm", bus_if.LD_alarm, 0);
        bus_if.req1 = 1'b0;
        tick();

        // Invalid hours 24 from requester 0
        bus_if.req0 = 1'b1; bus_if.kind0 = 1'b0; bus_if.hh0 = 6'h24; bus_if.mm0 = 8'h00;
        tick();  // c1
        chk("t3_ack0", bus_if.ack0, 1);
        chk("t3_err", bus_if.err, 1);
        chk("t3_strobe", {bus_if.LD_time, bus_if.LD_alarm}, 0);
        chk_digits("t3", 6'h00, 8'h00);
        bus_if.req0 = 1'b0;
        tick();

        // Invalid minutes 60 from requester 1
        bus_if.req1 = 1'b1; bus_if.kind1 = 1'b1; bus_if.hh1 = 6'h00; bus_if.mm1 = 8'h60;
        tick();  // c1
        chk("t4_ack1", bus_if.ack1, 1);
        chk("t4_err", bus_if.err, 1);
        chk("t4_strobe", {bus_if.LD_time, bus_if.LD_alarm}, 0);
        chk_digits("t4", 6'h00, 8'h00);
        bus_if.req1 = 1'b0;
        tick();
        chk("t4_idle_err", bus_if.err, 0);

        // Both requesting out of reset: round-robin 0,1,0,1
        reset = 1'b1;
        tick();
        bus_if.kind0 = 1'b1; bus_if.hh0 = 6'h06; bus_if.mm0 = 8'h15;
        bus_if.kind1 = 1'b1; bus_if.hh1 = 6'h19; bus_if.mm1 = 8'h45;
        bus_if.req0 = 1'b1;  bus_if.req1 = 1'b1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();  // c1 of grant k
            chk($sformatf("rr%0d_grant", k), bus_if.grant_id, k % 2);
            chk($sformatf("rr%0d_ldalarm", k), bus_if.LD_alarm, 1);
            if (k % 2 == 0) chk_digits($sformatf("rr%0d", k), 6'h06, 8'h15);
            else            chk_digits($sformatf("rr%0d", k), 6'h19, 8'h45);
            tick();
            tick();  // c3
            chk($sformatf("rr%0d_acks", k), {bus_if.ack1, bus_if.ack0},
                (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();  // idle
            chk($sformatf("rr%0d_idle", k), bus_if.busy, 0);
        end
        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
        tick();

        // Readback mismatch: model returns M0=5 after 4 was loaded
        corrupt = 1'b1;
        bus_if.req0 = 1'b1; bus_if.kind0 = 1'b0; bus_if.hh0 = 6'h12; bus_if.mm0 = 8'h34;
        tick();  // c1
        chk("t5_c1_ldtime", bus_if.LD_time, 1);
        tick(); tick(); tick(); tick();  // c5
        chk("t5_c5_ack", bus_if.ack0, 0);
        tick();  // c6
        chk("t5_c6_ack0", bus_if.ack0, 1);
        chk("t5_c6_err", bus_if.err, 1);
        bus_if.req0 = 1'b0;
        corrupt = 1'b0;
        tick();

        // Reset in the second LOAD cycle, then 23:59 re-granted and completed
        bus_if.req0 = 1'b1; bus_if.kind0 = 1'b0; bus_if.hh0 = 6'h23; bus_if.mm0 = 8'h59;
        tick();  // c1
        chk("t6_c1_ldtime", bus_if.LD_time, 1);
        chk_digits("t6_c1", 6'h23, 8'h59);
        tick();  // c2
        chk("t6_c2_ldtime", bus_if.LD_time, 1);
        reset = 1'b1;
        tick();
        chk("t6_rst_ldtime", bus_if.LD_time, 0);
        chk("t6_rst_state", dbg_state, 0);
        chk("t6_rst_busy", bus_if.busy, 0);
        chk("t6_rst_ack", {bus_if.ack0, bus_if.ack1, bus_if.err}, 0);
        chk_digits("t6_rst", 6'h00, 8'h00);
        reset = 1'b0;
        tick();  // c1 of re-grant
        chk("t6_regrant_ldtime", bus_if.LD_time, 1);
        chk("t6_regrant_grant", bus_if.grant_id, 0);
        tick(); tick(); tick(); tick();  // c5
        chk("t6_c5_ack", bus_if.ack0, 0);
        tick();  // c6
        chk("t6_c6_ack0", bus_if.ack0, 1);
        chk("t6_c6_err", bus_if.err, 0);
        bus_if.req0 = 1'b0;
        tick();
        chk("t6_idle_busy", bus_if.busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
